// File: rtl/srl16_rs_feed.sv
// Sixteen-stage clock-enabled tap-addressable delay line with a registered,
// sync reset/set output stage and a fill tracker that flags genuine taps.
module srl16_rs_feed #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic       C,
    input  logic       CLR_N,
    input  logic       D,
    input  logic       CE,
    input  logic [3:0] A,
    input  logic       R,
    input  logic       S,
    output logic       Q,
    output logic       VALID,
    output logic       Q15
);

    localparam logic [4:0] FILL_MAX = 5'd16;

    logic [15:0] sr;
    logic [4:0]  fill;

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            sr <= INIT;
        end else if (CE) begin
            sr <= {sr[14:0], D};
        end
    end

    // Saturating count of samples shifted since reset; never wraps.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            fill <= '0;
        end else if (CE && (fill != FILL_MAX)) begin
            fill <= fill + 5'd1;
        end
    end

    // Tap and fill are both read pre-edge, so Q/VALID describe the same sample.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            Q     <= 1'b0;
            VALID <= 1'b0;
        end else begin
            if (R) begin
                Q <= 1'b0;
            end else if (S) begin
                Q <= 1'b1;
            end else begin
                Q <= sr[A];
            end
            VALID <= !R && (fill > {1'b0, A});
        end
    end

    assign Q15 = sr[15];

endmodule
